// File: rtl/range_updown_counter.sv
// Up/down modulo counter over [MIN..MAX] with clamped parallel load and cascade carry-out.
// Optional saturation mode (adds the sat port) is enabled by defining RANGE_CNT_SAT_EN.
module range_updown_counter #(
    parameter int WIDTH = 4,
    parameter int MIN   = 2,
    parameter int MAX   = 9
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ce,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] data,
    output logic [WIDTH-1:0] dout,
    output logic             cout,
    output logic             wrap
`ifdef RANGE_CNT_SAT_EN
    ,
    input  logic             sat
`endif
);

    localparam logic [WIDTH-1:0] MIN_V = WIDTH'(MIN);
    localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX);

    logic [WIDTH-1:0] dout_q, dout_d;
    logic             wrap_q, wrap_d;
    logic             at_max, at_min, in_range;
    logic             sat_hold;

`ifdef RANGE_CNT_SAT_EN
    assign sat_hold = sat;
`else
    assign sat_hold = 1'b0;
`endif

    assign at_max   = (dout_q == MAX_V);
    assign at_min   = (dout_q == MIN_V);
    assign in_range = (dout_q >= MIN_V) && (dout_q <= MAX_V);

    // Terminal compare happens before any step, so MIN==0 never needs a borrow.
    always_comb begin
        dout_d = dout_q;
        wrap_d = 1'b0;
        if (load) begin
            if (data < MIN_V) begin
                dout_d = MIN_V;
            end else if (data > MAX_V) begin
                dout_d = MAX_V;
            end else begin
                dout_d = data;
            end
        end else if (ce) begin
            if (!in_range) begin
                dout_d = MIN_V;
            end else if (up) begin
                if (at_max) begin
                    if (!sat_hold) begin
                        dout_d = MIN_V;
                        wrap_d = 1'b1;
                    end
                end else begin
                    dout_d = dout_q + WIDTH'(1);
                end
            end else begin
                if (at_min) begin
                    if (!sat_hold) begin
                        dout_d = MAX_V;
                        wrap_d = 1'b1;
                    end
                end else begin
                    dout_d = dout_q - WIDTH'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            dout_q <= MIN_V;
            wrap_q <= 1'b0;
        end else begin
            dout_q <= dout_d;
            wrap_q <= wrap_d;
        end
    end

    // Combinational so the next stage steps on the same edge this one wraps.
    assign cout = ce & ((up & at_max) | (~up & at_min));
    assign dout = dout_q;
    assign wrap = wrap_q;

endmodule

// File: tb/tb_range_updown_counter.sv
// Bench for range_updown_counter: a two-digit chain (hi.ce = lo.cout) checked every cycle
// against a modulo-arithmetic model, plus directed literal expectations.
module tb_range_updown_counter;

    localparam int WIDTH = 4;
    localparam int MIN   = 2;
    localparam int MAX   = 9;
    localparam int RANGE = MAX - MIN + 1;

    logic             clk;
    logic             rst;
    logic             ce;
    logic             up;
    logic             load;
    logic [WIDTH-1:0] data;
    logic [WIDTH-1:0] lo_dout, hi_dout;
    logic             lo_cout, hi_cout;
    logic             lo_wrap, hi_wrap;

    int checks = 0;
    int errors = 0;
    bit check_en = 1'b0;

    // model state
    int m_lo = MIN;
    int m_hi = MIN;
    bit m_lo_wrap = 1'b0;
    bit m_hi_wrap = 1'b0;

    range_updown_counter #(.WIDTH(WIDTH), .MIN(MIN), .MAX(MAX)) u_lo (
        .clk  (clk),
        .rst  (rst),
        .ce   (ce),
        .up   (up),
        .load (load),
        .data (data),
        .dout (lo_dout),
        .cout (lo_cout),
        .wrap (lo_wrap)
    );

    range_updown_counter #(.WIDTH(WIDTH), .MIN(MIN), .MAX(MAX)) u_hi (
        .clk  (clk),
        .rst  (rst),
        .ce   (lo_cout),
        .up   (1'b1),
        .load (1'b0),
        .data (4'd0),
        .dout (hi_dout),
        .cout (hi_cout),
        .wrap (hi_wrap)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic bit model_cout(int v, bit c, bit u);
        return c && (u ? (v == MAX) : (v == MIN));
    endfunction

    function automatic int clamp(int d);
        if (d < MIN) return MIN;
        if (d > MAX) return MAX;
        return d;
    endfunction

    // position within the range, stepped modulo RANGE
    task automatic model_step(input int v, input bit u, output int nv, output bit w);
        int pos;
        if (v < MIN || v > MAX) begin
            nv = MIN;
            w  = 1'b0;
        end else begin
            pos = v - MIN + (u ? 1 : -1);
            w   = (pos < 0) || (pos >= RANGE);
            nv  = MIN + ((pos + RANGE) % RANGE);
        end
    endtask

    always @(posedge clk) begin
        int lo_n, hi_n;
        bit lo_w, hi_w, lo_c;
        lo_c = model_cout(m_lo, ce, up);
        lo_n = m_lo; lo_w = 1'b0;
        hi_n = m_hi; hi_w = 1'b0;
        if (!rst) begin
            lo_n = MIN;
            hi_n = MIN;
        end else begin
            if (load) lo_n = clamp(int'(data));
            else if (ce) model_step(m_lo, up, lo_n, lo_w);
            if (lo_c) model_step(m_hi, 1'b1, hi_n, hi_w);
        end
        m_lo = lo_n; m_lo_wrap = lo_w;
        m_hi = hi_n; m_hi_wrap = hi_w;
    end

    // scoreboard helper
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // per-cycle compare against the model
    always @(negedge clk) begin
        if (check_en) begin
            check("lo_dout", 32'(lo_dout), 32'(m_lo));
            check("lo_wrap", 32'(lo_wrap), 32'(m_lo_wrap));
            check("lo_cout", 32'(lo_cout), 32'(model_cout(m_lo, ce, up)));
            check("hi_dout", 32'(hi_dout), 32'(m_hi));
            check("hi_wrap", 32'(hi_wrap), 32'(m_hi_wrap));
            check("hi_cout", 32'(hi_cout), 32'(model_cout(m_hi, model_cout(m_lo, ce, up), 1'b1)));
        end
    end

    // driver tasks
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic drive(input bit r, input bit c, input bit u, input bit l, input int d);
        rst  = r;
        ce   = c;
        up   = u;
        load = l;
        data = WIDTH'(d);
    endtask

    // direction/enable pattern mixing holds, loads and direction changes
    localparam int NPAT = 16;
    int pat_ce[NPAT]   = '{1, 1, 0, 1, 1, 1, 0, 1, 1, 1, 1, 0, 1, 1, 1, 1};
    int pat_up[NPAT]   = '{0, 0, 0, 0, 1, 1, 1, 0, 1, 1, 1, 0, 0, 0, 0, 1};
    int pat_ld[NPAT]   = '{0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0};
    int pat_data[NPAT] = '{0, 0, 0, 0, 0, 8, 0, 0, 0, 0, 0, 0, 3, 0, 0, 0};

    initial begin
        drive(1'b0, 1'b0, 1'b1, 1'b0, 0);
        tick(1);
        check_en = 1'b1;
        drive(1'b1, 1'b0, 1'b1, 1'b0, 0);

        // reset state, hold with ce=0
        check("rst_dout", 32'(lo_dout), 32'd2);
        check("rst_wrap", 32'(lo_wrap), 32'd0);
        check("rst_cout", 32'(lo_cout), 32'd0);
        tick(5);
        check("hold_dout", 32'(lo_dout), 32'd2);

        // count up 3..9, then wrap to 2
        drive(1'b1, 1'b1, 1'b1, 1'b0, 0);
        tick(7);
        check("up_at_max", 32'(lo_dout), 32'd9);
        check("up_cout", 32'(lo_cout), 32'd1);
        tick(1);
        check("up_wrap_dout", 32'(lo_dout), 32'd2);
        check("up_wrap_pulse", 32'(lo_wrap), 32'd1);
        check("up_hi_step", 32'(hi_dout), 32'd3);
        tick(1);
        check("up_after_wrap", 32'(lo_dout), 32'd3);
        check("up_wrap_cleared", 32'(lo_wrap), 32'd0);

        // count down from 2: wrap to 9, then 8
        drive(1'b1, 1'b1, 1'b0, 1'b1, 2);
        tick(1);
        drive(1'b1, 1'b1, 1'b0, 1'b0, 0);
        check("dn_cout", 32'(lo_cout), 32'd1);
        tick(1);
        check("dn_wrap_dout", 32'(lo_dout), 32'd9);
        check("dn_wrap_pulse", 32'(lo_wrap), 32'd1);
        tick(1);
        check("dn_step", 32'(lo_dout), 32'd8);

        // loads with ce=1, including clamping
        drive(1'b1, 1'b1, 1'b1, 1'b1, 5);
        tick(1);
        check("load_5", 32'(lo_dout), 32'd5);
        check("load_wrap", 32'(lo_wrap), 32'd0);
        drive(1'b1, 1'b1, 1'b1, 1'b1, 0);
        tick(1);
        check("load_clamp_lo", 32'(lo_dout), 32'd2);
        drive(1'b1, 1'b1, 1'b1, 1'b1, 15);
        tick(1);
        check("load_clamp_hi", 32'(lo_dout), 32'd9);

        // chain from 2/2: after 8 edges lo=2, hi=3
        drive(1'b0, 1'b0, 1'b1, 1'b0, 0);
        tick(1);
        drive(1'b1, 1'b1, 1'b1, 1'b0, 0);
        tick(8);
        check("chain_lo", 32'(lo_dout), 32'd2);
        check("chain_hi", 32'(hi_dout), 32'd3);

        // mixed pattern, model-checked every cycle
        for (int i = 0; i < NPAT; i++) begin
            drive(1'b1, pat_ce[i][0], pat_up[i][0], pat_ld[i][0], pat_data[i]);
            tick(1);
        end

        // reset mid-count at 7 overrides load
        drive(1'b1, 1'b1, 1'b1, 1'b1, 2);
        tick(1);
        drive(1'b1, 1'b1, 1'b1, 1'b0, 0);
        tick(5);
        check("mid_at_7", 32'(lo_dout), 32'd7);
        drive(1'b0, 1'b1, 1'b1, 1'b1, 4);
        tick(1);
        check("mid_rst_dout", 32'(lo_dout), 32'd2);
        check("mid_rst_wrap", 32'(lo_wrap), 32'd0);

        // reset on the edge that would wrap clears the pulse
        drive(1'b1, 1'b1, 1'b1, 1'b1, 9);
        tick(1);
        drive(1'b0, 1'b1, 1'b1, 1'b0, 0);
        tick(1);
        check("rst_on_wrap_dout", 32'(lo_dout), 32'd2);
        check("rst_on_wrap_wrap", 32'(lo_wrap), 32'd0);
        drive(1'b1, 1'b0, 1'b1, 1'b0, 0);
        tick(2);

        check_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
